shift_chain_loader: RTL and testbench

- Upstream driver for the async-reset shift chain, whose `push` input acts as its shift clock.
- Accepts a parallel word over a valid/ready handshake.
- Serialises the word MSB-first onto the chain's serial data input.
- Generates a clean, clk-synchronous `push` strobe with guaranteed data setup and hold around every rising edge.
- After BITS pushes, the chain's parallel output equals the accepted word.

---
 rtl/shift_chain_loader.sv | 198 +++++++++++++++++++
 tb/tb_shift_chain_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_loader.sv
// shift_chain_loader
// -----------------------------------------------------------------------------
// Upstream driver for a shift chain whose `push` input acts as its shift clock.
// A parallel word is accepted over a valid/ready handshake. It is then
// serialised MSB-first onto d_out. Each bit gets one clean, clk-synchronous
// push pulse. d_out is stable SETUP_CYC cycles before every rising edge of
// push. It stays stable while push is high and for LOW_CYC cycles after push
// falls. After BITS pushes, the chain holds the accepted word.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-low reset
//   in_valid  in_data is valid
//   in_data   parallel word to load into the chain (BITS wide)
//   in_ready  block can accept a word (high only in IDLE)
//   push      shift strobe to the chain (acts as its clock)
//   d_out     serial data to the chain's data input
//   busy      transfer in progress (SETUP/PULSE/LOW/DONE)
//   done      one-cycle pulse after the last push has completed
// -----------------------------------------------------------------------------
module shift_chain_loader #(
    parameter int BITS      = 8,
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 1,
    parameter int LOW_CYC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    output logic            push,
    output logic            d_out,
    output logic            busy,
    output logic            done
);

    // A zero or negative width or phase length has no meaning.
    // Refuse to elaborate such a configuration.
    generate
        if (BITS < 1 || SETUP_CYC < 1 || HIGH_CYC < 1 || LOW_CYC < 1) begin : g_bad_params
            $error("shift_chain_loader: BITS, SETUP_CYC, HIGH_CYC and LOW_CYC must all be >= 1");
        end
    endgenerate

    localparam int PH_MAX = (SETUP_CYC > HIGH_CYC) ?
                            ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC) :
                            ((HIGH_CYC  > LOW_CYC) ? HIGH_CYC  : LOW_CYC);
    localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BC_W = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [PH_W-1:0] S_LAST  = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] H_LAST  = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] L_LAST  = PH_W'(LOW_CYC - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [BITS-1:0]   sreg_reg,  sreg_next;
    logic [BC_W-1:0]   bc_reg,    bc_next;
    logic [PH_W-1:0]   ph_reg,    ph_next;
    logic              push_reg,  push_next;
    logic              busy_reg,  busy_next;
    logic              done_reg,  done_next;
    logic              ready_reg, ready_next;

    // sreg shifted left by one. Its MSB is the next bit to present.
    logic [BITS-1:0]   sreg_shifted;

    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign sreg_shifted[gi] = 1'b0;
            end else begin : g_upper
                assign sreg_shifted[gi] = sreg_reg[gi-1];
            end
        end
    endgenerate

    // State register. push is cleared asynchronously by rst, so the chain
    // never sees a stray edge during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            bc_reg    <= '0;
            ph_reg    <= '0;
            push_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            bc_reg    <= bc_next;
            ph_reg    <= ph_next;
            push_reg  <= push_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ready_reg <= ready_next;
        end
    end

    // Next-state logic. Every output is the registered copy of a *_next value.
    // This keeps push and d_out glitch-free.
    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        bc_next    = bc_reg;
        ph_next    = ph_reg;
        push_next  = push_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;
        ready_next = ready_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid && ready_reg) begin
                    sreg_next  = in_data;
                    bc_next    = '0;
                    ph_next    = '0;
                    busy_next  = 1'b1;
                    ready_next = 1'b0;
                    state_next = SETUP;
                end
            end

            SETUP: begin
                if (ph_reg == S_LAST) begin
                    ph_next    = '0;
                    push_next  = 1'b1;
                    state_next = PULSE;
                end else begin
                    ph_next = ph_reg + PH_W'(1);
                end
            end

            PULSE: begin
                if (ph_reg == H_LAST) begin
                    ph_next    = '0;
                    push_next  = 1'b0;
                    state_next = LOW;
                end else begin
                    ph_next = ph_reg + PH_W'(1);
                end
            end

            LOW: begin
                if (ph_reg == L_LAST) begin
                    ph_next = '0;
                    if (bc_reg == BC_LAST) begin
                        // Leave sreg unshifted, so d_out keeps the last bit in IDLE.
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        sreg_next  = sreg_shifted;
                        bc_next    = bc_reg + BC_W'(1);
                        state_next = SETUP;
                    end
                end else begin
                    ph_next = ph_reg + PH_W'(1);
                end
            end

            DONE: begin
                done_next  = 1'b0;
                busy_next  = 1'b0;
                ready_next = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                push_next  = 1'b0;
                busy_next  = 1'b0;
                done_next  = 1'b0;
                ready_next = 1'b1;
            end
        endcase
    end

    // d_out is the MSB of the shift register itself. It is already a flop
    // output, loaded with in_data[BITS-1] on accept.
    assign d_out    = sreg_reg[BITS-1];
    assign push     = push_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign in_ready = ready_reg;

endmodule

// File: tb/tb_shift_chain_loader.sv
// Testbench for shift_chain_loader.
// Three instances cover three configurations:
//   a: BITS=8, S/H/L = 1/1/1
//   b: BITS=8, S/H/L = 2/3/1
//   c: BITS=1, S/H/L = 1/1/1
// Only the instance selected by `sel` receives in_valid. Its outputs are
// muxed onto one monitor. Each instance drives a behavioural chain model
// clocked by its push. The stimulus pushes the expected word and accept
// edge into a queue. The monitor pops an entry at every done pulse and
// checks the chain, the push count and the latency. It also checks push
// width, push period and d_out stability on every pulse.
module tb_shift_chain_loader;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [7:0] in_data;
    int   sel;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always_ff @(posedge clk) cyc <= cyc + 1;

    logic v_a, v_b, v_c;
    logic rdy_a, push_a, d_a, busy_a, done_a;
    logic rdy_b, push_b, d_b, busy_b, done_b;
    logic rdy_c, push_c, d_c, busy_c, done_c;
    logic [0:0] data_c;

    assign v_a    = in_valid && (sel == 0);
    assign v_b    = in_valid && (sel == 1);
    assign v_c    = in_valid && (sel == 2);
    assign data_c = in_data[0:0];

    shift_chain_loader #(.BITS(8), .SETUP_CYC(1), .HIGH_CYC(1), .LOW_CYC(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(v_a), .in_data(in_data), .in_ready(rdy_a),
        .push(push_a), .d_out(d_a), .busy(busy_a), .done(done_a));

    shift_chain_loader #(.BITS(8), .SETUP_CYC(2), .HIGH_CYC(3), .LOW_CYC(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(v_b), .in_data(in_data), .in_ready(rdy_b),
        .push(push_b), .d_out(d_b), .busy(busy_b), .done(done_b));

    shift_chain_loader #(.BITS(1), .SETUP_CYC(1), .HIGH_CYC(1), .LOW_CYC(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(v_c), .in_data(data_c), .in_ready(rdy_c),
        .push(push_c), .d_out(d_c), .busy(busy_c), .done(done_c));

    // Chain models: async-reset shift registers clocked by push.
    logic [7:0] chain_a, chain_b;
    logic       chain_c;
    always_ff @(posedge push_a or negedge rst)
        if (!rst) chain_a <= '0; else chain_a <= {chain_a[6:0], d_a};
    always_ff @(posedge push_b or negedge rst)
        if (!rst) chain_b <= '0; else chain_b <= {chain_b[6:0], d_b};
    always_ff @(posedge push_c or negedge rst)
        if (!rst) chain_c <= 1'b0; else chain_c <= d_c;

    // Outputs and parameters of the selected instance.
    logic m_ready, m_push, m_d, m_busy, m_done;
    logic [7:0] m_chain;
    int cur_bits, cur_s, cur_h, cur_l, cur_p;
    always_comb begin
        m_ready = rdy_a; m_push = push_a; m_d = d_a; m_busy = busy_a; m_done = done_a;
        m_chain = chain_a; cur_bits = 8; cur_s = 1; cur_h = 1; cur_l = 1;
        if (sel == 1) begin
            m_ready = rdy_b; m_push = push_b; m_d = d_b; m_busy = busy_b; m_done = done_b;
            m_chain = chain_b; cur_s = 2; cur_h = 3; cur_l = 1;
        end else if (sel == 2) begin
            m_ready = rdy_c; m_push = push_c; m_d = d_c; m_busy = busy_c; m_done = done_c;
            m_chain = {7'b0, chain_c}; cur_bits = 1;
        end
        cur_p = cur_s + cur_h + cur_l;
    end

    typedef struct {
        logic [7:0] word;
        int         acc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    int  rises = 0;
    int  last_rise = 0;
    int  high_cnt = 0;
    int  since_fall = 1000;
    int  stable = 1000;
    logic prev_push = 1'b0;
    logic prev_d = 1'b0;
    bit  done_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                rises = 0; high_cnt = 0; since_fall = 1000; stable = 1000;
                prev_push = m_push; prev_d = m_d; done_prev = 1'b0;
            end else begin
                since_fall++;
                stable++;
                if (done_prev)
                    check("idle_after_done", int'(m_ready && !m_busy && !m_done), 1);
                done_prev = m_done;
                if (m_d != prev_d) begin
                    check("d_chg_push_low", int'(m_push), 0);
                    check("d_hold_after_fall", int'(since_fall >= cur_l), 1);
                    stable = 0;
                end
                if (m_push && !prev_push) begin
                    if (sb.size() == 0 || rises >= cur_bits) begin
                        check("unexpected_push", rises, -1);
                    end else begin
                        logic [7:0] w;
                        w = sb[0].word;
                        check("d_at_rise", int'(m_d), int'(w[cur_bits-1-rises]));
                    end
                    check("setup_stable", int'(stable >= cur_s), 1);
                    if (rises > 0) check("push_period", cyc - last_rise, cur_p);
                    last_rise = cyc;
                    high_cnt = 0;
                    rises++;
                end
                if (m_push) high_cnt++;
                if (!m_push && prev_push) begin
                    check("push_high_width", high_cnt, cur_h);
                    since_fall = 0;
                end
                if (m_done) begin
                    check("busy_at_done", int'(m_busy), 1);
                    if (sb.size() == 0) begin
                        check("done_without_word", 0, 1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("chain_value", int'(m_chain), int'(e.word));
                        check("push_count", rises, cur_bits);
                        check("done_latency", cyc - e.acc, cur_bits * cur_p);
                    end
                    rises = 0;
                end
                prev_push = m_push;
                prev_d = m_d;
            end
        end
    end

    int last_acc = 0;

    // Wait for in_ready and present the word; the next edge accepts it.
    task automatic send(input logic [7:0] w, input bit keep);
        int n = 0;
        @(negedge clk);
        while (!m_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check("ready_timeout", 0, 1);
        end else begin
            in_data = w;
            in_valid = 1'b1;
            sb.push_back('{w, cyc + 1});
            last_acc = cyc + 1;
            @(posedge clk);
            #1;
            check("ready_drop_on_accept", int'(m_ready), 0);
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !m_ready) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic reset_select(input int s);
        @(negedge clk);
        rst = 1'b0;
        sel = s;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int acc1;
        int n;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_push", int'(m_push), 0);
        check("rst_d_out", int'(m_d), 0);
        check("rst_busy", int'(m_busy), 0);
        check("rst_done", int'(m_done), 0);
        check("rst_in_ready", int'(m_ready), 1);
        #1 rst = 1'b1;

        // Single word.
        send(8'hA5, 1'b0);
        wait_idle();

        // Back-to-back: in_valid held, next word presented once ready returns.
        send(8'h3C, 1'b1);
        acc1 = last_acc;
        send(8'hC3, 1'b0);
        check("b2b_gap", last_acc - acc1, 26);
        wait_idle();

        // in_valid while busy must be ignored.
        send(8'h00, 1'b0);
        repeat (6) @(negedge clk);
        in_data = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        check("ready_low_while_busy", int'(m_ready), 0);
        in_valid = 1'b0;
        wait_idle();
        check("chain_after_ignored", int'(chain_a), 0);

        // Reset in the middle of a transfer.
        send(8'h5A, 1'b0);
        n = 0;
        while (!(rises == 3 && !m_push) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("three_pushes_seen", rises, 3);
        #2 rst = 1'b0;
        #1;
        check("midrst_push", int'(m_push), 0);
        check("midrst_busy", int'(m_busy), 0);
        check("midrst_done", int'(m_done), 0);
        check("midrst_in_ready", int'(m_ready), 1);
        check("midrst_chain", int'(chain_a), 0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        send(8'h0F, 1'b0);
        wait_idle();

        // Stretched timing: S=2, H=3, L=1.
        reset_select(1);
        send(8'h81, 1'b0);
        wait_idle();

        // Single-bit chain.
        reset_select(2);
        send(8'h01, 1'b0);
        wait_idle();
        check("bits1_d_kept", int'(m_d), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
